// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states (3-bit encoding).
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } state_t;

  // First writable address; data writes below it are dropped.
  localparam logic [15:0] ROM_TOP_DEFAULT     = 16'h1000;
  // Consecutive data grants allowed while a fetch waits.
  localparam int          MAX_D_BURST_DEFAULT = 4;
  // BUSY cycles without mem_rdy before an access is abandoned.
  localparam int          TIMEOUT_DEFAULT     = 16;
  // Word returned to the requester when an access is abandoned.
  localparam logic [15:0] ABORT_WORD          = 16'hDEAD;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Grant selection between fetch and data ports, plus the data burst counter
// that guarantees a waiting fetch is served after MAX_D_BURST data grants.
module arb_prio #(
  parameter int MAX_D_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic i_req,
  input  logic d_req,
  input  logic take_i,
  input  logic take_d,
  output logic gnt_i,
  output logic gnt_d
);

  localparam int            CW      = $clog2(MAX_D_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_D_BURST);

  logic [CW-1:0] burst_cnt;
  logic          at_limit;

  assign at_limit = i_req && (burst_cnt == CNT_MAX);

  // Data wins unless a fetch is waiting and the data burst is used up.
  always_comb begin
    gnt_d = en && d_req && !at_limit;
    gnt_i = en && i_req && !gnt_d;
  end

  // Count data grants made while a fetch waits; clear once the fetch is
  // served or nobody is waiting for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
    end else if (take_i) begin
      burst_cnt <= '0;
    end else if (take_d && i_req) begin
      if (burst_cnt != CNT_MAX) burst_cnt <= burst_cnt + 1'b1;
    end else if (en && !i_req) begin
      burst_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch port and the data port.
// Data has priority; fetches are guaranteed service after a bounded data
// burst. Data writes below ROM_TOP are dropped without touching memory.
// Optional build macro: MEM_ARB_TIMEOUT_EN adds a BUSY watchdog and the
// timeout output.
//
// Handshake: a port raises req with its address/data stable and holds it
// until it sees its one-cycle hit pulse; the hit cycle is the only cycle in
// which the returned word is new. On the memory side mem_en is held with
// stable mem_addr/mem_we/mem_wdata until the cycle mem_rdy=1, which both
// completes the access and qualifies mem_rdata.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [15:0] ROM_TOP     = ROM_TOP_DEFAULT,
  parameter int          MAX_D_BURST = MAX_D_BURST_DEFAULT
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int        TIMEOUT     = TIMEOUT_DEFAULT
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_hit,
  output logic [15:0] instr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_hit,
  output logic [15:0] d_data,
  output logic        wr_drop,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdy,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic        timeout,
`endif
  output logic [2:0]  fsm_state
);

  state_t state;
  logic   idle;
  logic   gnt_i;
  logic   gnt_d;
  logic   rom_drop;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`endif

  assign idle      = (state == IDLE);
  assign rom_drop  = d_we && (d_addr < ROM_TOP);
  assign fsm_state = state;

  arb_prio #(
    .MAX_D_BURST(MAX_D_BURST)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .en    (idle),
    .i_req (i_req),
    .d_req (d_req),
    .take_i(gnt_i),
    .take_d(gnt_d),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );

  // Arbiter FSM with registered memory strobes, hit pulses and result words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      i_hit     <= 1'b0;
      d_hit     <= 1'b0;
      wr_drop   <= 1'b0;
      instr     <= '0;
      d_data    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      i_hit   <= 1'b0;
      d_hit   <= 1'b0;
      wr_drop <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (gnt_d) begin
            if (rom_drop) begin
              // Protected write: complete at once, memory never sees it.
              state   <= D_DONE;
              d_hit   <= 1'b1;
              wr_drop <= 1'b1;
            end else begin
              state     <= D_BUSY;
              mem_en    <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end
          end else if (gnt_i) begin
            state    <= I_BUSY;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
          end
        end
        I_BUSY: begin
          if (mem_rdy) begin
            instr  <= mem_rdata;
            state  <= I_DONE;
            i_hit  <= 1'b1;
            mem_en <= 1'b0;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            instr   <= ABORT_WORD;
            timeout <= 1'b1;
            state   <= I_DONE;
            i_hit   <= 1'b1;
            mem_en  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        D_BUSY: begin
          if (mem_rdy) begin
            if (!mem_we) d_data <= mem_rdata;
            state  <= D_DONE;
            d_hit  <= 1'b1;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            if (!mem_we) d_data <= ABORT_WORD;
            timeout <= 1'b1;
            state   <= D_DONE;
            d_hit   <= 1'b1;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        I_DONE, D_DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: reset checks, a table of single transactions,
// hand-written contention / reset-mid-access / timeout sequences, and a
// randomized two-port run against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int          MAXB = 4;
  localparam logic [15:0] ROMT = 16'h1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_hit;
  logic [15:0] instr;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_hit;
  logic [15:0] d_data;
  logic        wr_drop;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_rdy = 1'b0;
  logic [2:0]  fsm_state;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        timeout;
`endif

  mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_hit    (i_hit),
    .instr    (instr),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_hit    (d_hit),
    .d_data   (d_data),
    .wr_drop  (wr_drop),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_rdy  (mem_rdy),
`ifdef MEM_ARB_TIMEOUT_EN
    .timeout  (timeout),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] init_word(logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // ---------------- memory responder ----------------
  // mode 0: never ready; 1: ready after fix_wait stall cycles, returns
  // fix_rdata (its complement while stalling); 2: random 0..3 stalls,
  // backed by a sparse memory, random mem_rdy noise while not busy.
  int          resp_mode = 0;
  int          fix_wait = 0;
  logic [15:0] fix_rdata = '0;
  int          busy_idx = 0;
  int          rand_lat = 0;
  int          resp_lat = 0;
  int          en_total = 0;
  int          addr_changes = 0;
  logic [15:0] last_addr = '0;
  logic        last_we = 1'b0;
  logic [15:0] mem_arr [logic [15:0]];

  always @(negedge clk) begin
    if (mem_en) begin
      en_total++;
      if (busy_idx > 0 && mem_addr !== last_addr) addr_changes++;
      last_addr = mem_addr;
      last_we   = mem_we;
      if (busy_idx == 0) rand_lat = $urandom_range(0, 3);
      resp_lat = (resp_mode == 1) ? fix_wait : rand_lat;
      if (resp_mode != 0 && busy_idx == resp_lat) begin
        mem_rdy = 1'b1;
        if (resp_mode == 2) begin
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr);
        end else begin
          mem_rdata = fix_rdata;
        end
      end else begin
        mem_rdy   = 1'b0;
        mem_rdata = (resp_mode == 1) ? ~fix_rdata : 16'($urandom);
      end
      busy_idx++;
    end else begin
      busy_idx  = 0;
      mem_rdy   = (resp_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = 16'($urandom);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_d;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          wait_n;
    logic [15:0] rdata;
    int          exp_lat;
    int          exp_en;
    logic        exp_drop;
    logic [15:0] exp_word;
    logic        exp_to;
  } vec_t;

  localparam int NV = 9;
  vec_t        tbl [NV];
  logic [15:0] exp_instr = '0;
  logic [15:0] exp_ddata = '0;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One isolated transaction on an idle arbiter with a fixed-latency memory.
  task automatic run_vec(input vec_t v, input int idx);
    int   en0;
    int   ch0;
    int   lat;
    logic drop_seen;
    logic to_seen;
    string tag;
    tag       = $sformatf("v%0d", idx);
    resp_mode = 1;
    fix_wait  = v.wait_n;
    fix_rdata = v.rdata;
    en0       = en_total;
    ch0       = addr_changes;
    lat       = -1;
    drop_seen = 1'b0;
    to_seen   = 1'b0;
    if (v.is_d) begin
      d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
    end else begin
      i_addr = v.addr; i_req = 1'b1;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (v.is_d ? d_hit : i_hit) begin
        lat       = k;
        drop_seen = wr_drop;
`ifdef MEM_ARB_TIMEOUT_EN
        to_seen   = timeout;
`endif
        break;
      end
    end
    d_req = 1'b0;
    i_req = 1'b0;
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_mem_en_cycles"}, en_total - en0, v.exp_en);
    check({tag, "_wr_drop"}, drop_seen, v.exp_drop);
    check({tag, "_addr_stable"}, addr_changes - ch0, 0);
`ifdef MEM_ARB_TIMEOUT_EN
    check({tag, "_timeout"}, to_seen, v.exp_to);
`endif
    if (v.exp_en > 0) begin
      check({tag, "_mem_addr"}, last_addr, v.addr);
      check({tag, "_mem_we"}, last_we, v.we);
    end
    if (v.is_d) begin
      check({tag, "_d_data"}, d_data, v.exp_word);
      check({tag, "_instr_hold"}, instr, exp_instr);
      exp_ddata = v.exp_word;
    end else begin
      check({tag, "_instr"}, instr, v.exp_word);
      check({tag, "_d_data_hold"}, d_data, exp_ddata);
      exp_instr = v.exp_word;
    end
    @(negedge clk);
    check({tag, "_back_idle"}, fsm_state, IDLE);
  endtask

  // ---------------- randomized run: reference model ----------------
  localparam int N_RAND = 150;
  logic [16:0] d_exp_q [$];   // {wr_drop, d_data}
  logic [15:0] i_exp_q [$];   // instr
  logic [15:0] model_mem [logic [15:0]];
  logic        d_done = 1'b0;
  logic        i_done = 1'b0;

  task automatic d_driver();
    logic [15:0] a;
    logic [15:0] w;
    logic        we;
    logic        drop;
    logic [15:0] last = '0;
    logic [15:0] word;
    logic [16:0] exp;
    bit          got;
    for (int t = 0; t < N_RAND; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 3))
        0:       a = 16'h0FF0 + 16'($urandom_range(0, 31));
        1:       a = 16'h2000 + 16'($urandom_range(0, 7));
        2:       a = 16'($urandom);
        default: a = 16'hFFF8 + 16'($urandom_range(0, 7));
      endcase
      we = 1'($urandom_range(0, 1));
      w  = 16'($urandom);
      drop = 1'b0;
      if (we) begin
        drop = (a < ROMT);
        if (!drop) model_mem[a] = w;
        word = last;
      end else begin
        word = model_mem.exists(a) ? model_mem[a] : init_word(a);
        last = word;
      end
      d_exp_q.push_back({drop, word});
      d_we = we; d_addr = a; d_wdata = w; d_req = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (d_hit) begin got = 1'b1; break; end
      end
      d_req = 1'b0;
      exp = d_exp_q.pop_front();
      if (!got) begin
        check("rand_d_hit_timeout", 0, 1);
        break;
      end
      check("rand_d_data", d_data, exp[15:0]);
      check("rand_wr_drop", wr_drop, exp[16]);
    end
    d_done = 1'b1;
  endtask

  task automatic i_driver();
    logic [15:0] a;
    logic [15:0] exp;
    bit          got;
    for (int t = 0; t < N_RAND; t++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      a = 16'($urandom_range(0, 16'h0FFF));
      i_exp_q.push_back(init_word(a));
      i_addr = a; i_req = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (i_hit) begin got = 1'b1; break; end
      end
      i_req = 1'b0;
      exp = i_exp_q.pop_front();
      if (!got) begin
        check("rand_i_hit_timeout", 0, 1);
        break;
      end
      check("rand_instr", instr, exp);
    end
    i_done = 1'b1;
  endtask

  // A waiting fetch sees at most one data grant made before it arrived plus
  // MAXB counted grants before it is served.
  task automatic fair_monitor();
    int streak = 0;
    while (!(d_done && i_done)) begin
      @(negedge clk);
      check("hit_overlap", i_hit & d_hit, 1'b0);
      if (i_hit) streak = 0;
      if (d_hit && i_req) begin
        streak++;
        check("burst_bound", streak <= MAXB + 1, 1'b1);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    string exp_order;
    string order;
    int    last_i;
    int    last_d;
    int    lat;

    tbl[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 0, 16'hBEEF, 2, 1, 1'b0, 16'hBEEF, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'h0FFF, 16'h1111, 0, 16'h0000, 1, 0, 1'b1, 16'hBEEF, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 16'h1000, 16'h2222, 1, 16'h0000, 3, 2, 1'b0, 16'hBEEF, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 4, 16'h0ABC, 6, 5, 1'b0, 16'h0ABC, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 0, 16'h7777, 2, 1, 1'b0, 16'h7777, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 2, 16'h0001, 4, 3, 1'b0, 16'h0001, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 16'h0000, 16'h5A5A, 0, 16'h0000, 1, 0, 1'b1, 16'h0001, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 16'hFFFF, 16'h3333, 0, 16'h0000, 2, 1, 1'b0, 16'h0001, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 16'h0FFF, 16'h0000, 0, 16'h4321, 2, 1, 1'b0, 16'h4321, 1'b0};

    // Reset values.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_i_hit", i_hit, 1'b0);
    check("rst_d_hit", d_hit, 1'b0);
    check("rst_wr_drop", wr_drop, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_d_data", d_data, 16'h0000);
    check("rst_state", fsm_state, IDLE);
    rst = 1'b1;
    @(negedge clk);

    // Table of isolated transactions.
    for (int v = 0; v < NV; v++) run_vec(tbl[v], v);

`ifdef MEM_ARB_TIMEOUT_EN
    // Abandoned fetch: memory never ready.
    begin
      vec_t tv;
      tv = '{1'b0, 1'b0, 16'h2000, 16'h0000, 100, 16'h1111, 17, 16, 1'b0, ABORT_WORD, 1'b1};
      run_vec(tv, 99);
    end
`endif

    // Contention with the burst limit, both requests held continuously.
    do_reset();
    resp_mode = 1; fix_wait = 0; fix_rdata = 16'h5555;
    i_addr = 16'h0100; d_addr = 16'h2000; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    exp_order = "DDDDIDDDDI";
    order = "";
    last_i = -10;
    last_d = -10;
    for (int k = 1; k <= 60 && order.len() < 10; k++) begin
      @(negedge clk);
      if (i_hit || d_hit) check("cont_overlap", i_hit & d_hit, 1'b0);
      if (i_hit) begin
        check("cont_i_gap", (k - last_i) > 1, 1'b1);
        last_i = k;
        order = {order, "I"};
      end
      if (d_hit) begin
        check("cont_d_gap", (k - last_d) > 1, 1'b1);
        last_d = k;
        order = {order, "D"};
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int j = 0; j < 10; j++)
      check($sformatf("cont_grant%0d", j), (j < order.len()) ? order[j] : 8'h3F, exp_order[j]);
    repeat (2) @(negedge clk);

    // Reset in the middle of a data access.
    resp_mode = 1; fix_wait = 20; fix_rdata = 16'h9999;
    d_addr = 16'h3000; d_we = 1'b0; d_req = 1'b1;
    repeat (2) @(negedge clk);
    check("rstmid_busy_en", mem_en, 1'b1);
    check("rstmid_busy_state", fsm_state, D_BUSY);
    rst = 1'b0;
    #1;
    check("rstmid_mem_en", mem_en, 1'b0);
    check("rstmid_d_hit", d_hit, 1'b0);
    check("rstmid_state", fsm_state, IDLE);
    check("rstmid_d_data", d_data, 16'h0000);
    @(negedge clk);
    fix_wait = 0; fix_rdata = 16'h6789;
    rst = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (d_hit) begin lat = k; break; end
    end
    d_req = 1'b0;
    check("rstmid_retry_latency", lat, 2);
    check("rstmid_retry_data", d_data, 16'h6789);
    repeat (2) @(negedge clk);

    // Randomized two-port traffic against the reference model.
    do_reset();
    resp_mode = 2;
    fork
      d_driver();
      i_driver();
      fair_monitor();
    join
    resp_mode = 0;
    check("rand_d_queue_empty", d_exp_q.size(), 0);
    check("rand_i_queue_empty", i_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
